calc_seq_ctrl: RTL and testbench

Parametrised keypad-calculator sequencer sitting between the decoded-keypad front end and the `alumdl` ALU / `ledtube` display path. It accumulates multi-digit decimal operands and an operator from key events, drives the ALU, post-processes the result (sign, compare, overflow), converts it to decimal, and streams digits to the display over a valid/ready handshake. It generalises the fixed three-digit top-level calculator with:

- configurable digit count, data width and ALU latency;
- operation chaining;
- overflow flagging;
- backpressure-safe digit output.

---
 rtl/calc_seq_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: keypad calculator sequencer between key decoder, ALU and display.
// Builds multi-digit operands from key events, drives the ALU, post-processes
// the result (sign, SLT, overflow), converts it to decimal and streams the
// digits out over a valid/ready handshake.
//
// Parameters: NDIG digits per operand/result, W data width, ALU_LAT ALU latency.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   key_vld, key_code     decoded key pulse (0-9 digit, A-E operator, F equals)
//   alu_a, alu_b, alu_cs  registered ALU operands / op code
//   alu_s                 ALU result
//   dig_vld/data/idx/rdy  digit stream to display (data 4'hA = minus)
//   dig_clr               one-cycle display blank pulse
//   busy, err             busy in WAIT/CONV/EMIT; sticky result overflow
// Build option: define CALC_NEG_EN to emit signed results for SUB with A<B;
// otherwise such a result is flagged in err and forced to 0.

module calc_seq_ctrl #(
   parameter int NDIG    = 3,
   parameter int W       = 11,
   parameter int ALU_LAT = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_vld,
   input  logic [3:0]   key_code,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [2:0]   alu_cs,
   input  logic [W-1:0] alu_s,
   output logic         dig_vld,
   output logic [3:0]   dig_data,
   output logic [2:0]   dig_idx,
   input  logic         dig_rdy,
   output logic         dig_clr,
   output logic         busy,
   output logic         err
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [W-1:0] LIM  = W'(10 ** NDIG);
   localparam logic [W-1:0] TEN  = W'(10);
   localparam logic [3:0]   MINUS = 4'hA;

   localparam logic [2:0] CS_AND = 3'b000;
   localparam logic [2:0] CS_OR  = 3'b001;
   localparam logic [2:0] CS_ADD = 3'b010;
   localparam logic [2:0] CS_SUB = 3'b011;
   localparam logic [2:0] CS_SLT = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AENT,
      S_BENT,
      S_WAIT,
      S_CONV,
      S_EMIT
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] acc_q, acc_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [2:0]   cs_q, cs_d;
   logic [W-1:0] opa_q, opa_d;
   logic [W-1:0] alu_a_q, alu_a_d;
   logic [W-1:0] alu_b_q, alu_b_d;
   logic [2:0]   alu_cs_q, alu_cs_d;
   logic         chain_q, chain_d;
   logic [W-1:0] res_q, res_d;
   logic         neg_q, neg_d;
   logic         err_q, err_d;
   logic [W-1:0] mag_q, mag_d;
   logic [3:0]   dbuf_q [NDIG];
   logic [3:0]   dbuf_d [NDIG];
   logic [3:0]   nd_q, nd_d;
   logic [3:0]   wcnt_q, wcnt_d;
   logic         vld_q, vld_d;
   logic [3:0]   data_q, data_d;
   logic [2:0]   idx_q, idx_d;
   logic         clr_q, clr_d;

   // key decode, only honoured in the entry states
   logic in_ent, is_dig, is_op, is_eq, dig_ok, xfer;
   logic [2:0] op_cs;

   always_comb begin
      in_ent = (state_q == S_IDLE) || (state_q == S_AENT) ||
               (state_q == S_BENT);
      is_dig = key_vld && in_ent && (key_code <= 4'd9);
      is_op  = key_vld && in_ent && (key_code >= 4'hA) &&
               (key_code <= 4'hE);
      is_eq  = key_vld && in_ent && (key_code == 4'hF);
      // IDLE always restarts the operand, so its count is taken as zero
      dig_ok = is_dig && !vld_q &&
               ((state_q == S_IDLE) || (cnt_q < 4'(NDIG)));
      xfer   = vld_q && dig_rdy;
      unique case (key_code)
         4'hA:    op_cs = CS_OR;
         4'hB:    op_cs = CS_AND;
         4'hC:    op_cs = CS_SLT;
         4'hD:    op_cs = CS_SUB;
         default: op_cs = CS_ADD;
      endcase
   end

   // result post-processing, used in the capture cycle
   logic         sub_lt, neg_c, ovf_c, err_c;
   logic [W-1:0] raw_c, mag_c, res_c;

   always_comb begin
      sub_lt = (alu_cs_q == CS_SUB) &&
               ($signed(alu_a_q) < $signed(alu_b_q));
      neg_c  = 1'b0;
      err_c  = 1'b0;
      raw_c  = alu_s;
      if (alu_cs_q == CS_SLT)
         raw_c = {{(W-1){1'b0}}, alu_s[0]};
`ifdef CALC_NEG_EN
      if (sub_lt) begin
         neg_c = 1'b1;
         raw_c = -alu_s;
      end
`else
      if (sub_lt) begin
         err_c = 1'b1;
         raw_c = '0;
      end
`endif
      ovf_c = (raw_c >= LIM);
      mag_c = ovf_c ? (raw_c % LIM) : raw_c;
      err_c = err_c | ovf_c;
      // chain keeps the signed value so a follow-on op sees e.g. -3
      res_c = neg_c ? -mag_c : mag_c;
   end

   // conversion and emit helpers
   logic [3:0]    dcur;
   logic [W-1:0]  mdiv;
   logic [3:0]    tot;
   logic [3:0]    pos;
   logic [IW-1:0] bi;
   logic          last;
   logic          lat_hit;

   always_comb begin
      dcur    = 4'(mag_q % TEN);
      mdiv    = mag_q / TEN;
      tot     = nd_q + {3'b000, neg_q};
      last    = ({1'b0, idx_q} == tot);
      // digits sit LS-first in dbuf; the item after idx_q is read MS-first
      pos     = {1'b0, idx_q} - {3'b000, neg_q};
      bi      = IW'(nd_q - 4'd1 - pos);
      lat_hit = (wcnt_q == 4'(ALU_LAT - 1));
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (dig_ok)                state_d = S_AENT;
            else if (is_op && chain_q) state_d = S_BENT;
         end
         S_AENT:  if (is_op)         state_d = S_BENT;
         S_BENT:  if (is_eq)         state_d = S_WAIT;
         S_WAIT:  if (lat_hit)       state_d = S_CONV;
         S_CONV:  if (mdiv == '0)    state_d = S_EMIT;
         S_EMIT:  if (xfer && last)  state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   // datapath next-state
   always_comb begin
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      cs_d     = cs_q;
      opa_d    = opa_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_cs_d = alu_cs_q;
      chain_d  = chain_q;
      res_d    = res_q;
      neg_d    = neg_q;
      err_d    = err_q;
      mag_d    = mag_q;
      dbuf_d   = dbuf_q;
      nd_d     = nd_q;
      wcnt_d   = wcnt_q;
      vld_d    = vld_q;
      data_d   = data_q;
      idx_d    = idx_q;
      clr_d    = 1'b0;

      // echo digits complete their handshake in any non-EMIT state
      if (xfer && state_q != S_EMIT)
         vld_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (dig_ok) begin
               chain_d = 1'b0;
               acc_d   = W'(key_code);
               cnt_d   = 4'd1;
               clr_d   = 1'b1;
               vld_d   = 1'b1;
               data_d  = key_code;
               idx_d   = 3'd1;
            end else if (is_op && chain_q) begin
               cs_d  = op_cs;
               opa_d = res_q;
               acc_d = '0;
               cnt_d = '0;
               clr_d = 1'b1;
            end
         end
         S_AENT, S_BENT: begin
            if (dig_ok) begin
               acc_d  = acc_q * TEN + W'(key_code);
               cnt_d  = cnt_q + 4'd1;
               vld_d  = 1'b1;
               data_d = key_code;
               idx_d  = 3'(cnt_q + 4'd1);
            end else if (is_op && state_q == S_AENT) begin
               cs_d  = op_cs;
               opa_d = acc_q;
               acc_d = '0;
               cnt_d = '0;
               clr_d = 1'b1;
            end else if (is_op && cnt_q == '0) begin
               cs_d = op_cs;
            end else if (is_eq && state_q == S_BENT) begin
               alu_a_d  = opa_q;
               alu_b_d  = acc_q;
               alu_cs_d = cs_q;
               err_d    = 1'b0;
               clr_d    = 1'b1;
               wcnt_d   = '0;
               acc_d    = '0;
               cnt_d    = '0;
            end
         end
         S_WAIT: begin
            if (lat_hit) begin
               neg_d   = neg_c;
               err_d   = err_c;
               mag_d   = mag_c;
               res_d   = res_c;
               chain_d = 1'b1;
               nd_d    = '0;
            end else begin
               wcnt_d = wcnt_q + 4'd1;
            end
         end
         S_CONV: begin
            dbuf_d[IW'(nd_q)] = dcur;
            nd_d  = nd_q + 4'd1;
            mag_d = mdiv;
            if (mdiv == '0) begin
               // the digit found now is the most significant one
               vld_d  = 1'b1;
               idx_d  = 3'd1;
               data_d = neg_q ? MINUS : dcur;
            end
         end
         S_EMIT: begin
            if (xfer) begin
               if (last) begin
                  vld_d = 1'b0;
               end else begin
                  idx_d  = idx_q + 3'd1;
                  data_d = dbuf_q[bi];
               end
            end
         end
         default: ;
      endcase
   end

   // datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         cs_q     <= '0;
         opa_q    <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_cs_q <= '0;
         chain_q  <= 1'b0;
         res_q    <= '0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
         mag_q    <= '0;
         for (int i = 0; i < NDIG; i++)
            dbuf_q[i] <= '0;
         nd_q     <= '0;
         wcnt_q   <= '0;
         vld_q    <= 1'b0;
         data_q   <= '0;
         idx_q    <= '0;
         clr_q    <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         cs_q     <= cs_d;
         opa_q    <= opa_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_cs_q <= alu_cs_d;
         chain_q  <= chain_d;
         res_q    <= res_d;
         neg_q    <= neg_d;
         err_q    <= err_d;
         mag_q    <= mag_d;
         dbuf_q   <= dbuf_d;
         nd_q     <= nd_d;
         wcnt_q   <= wcnt_d;
         vld_q    <= vld_d;
         data_q   <= data_d;
         idx_q    <= idx_d;
         clr_q    <= clr_d;
      end
   end

   // outputs
   always_comb begin
      busy     = (state_q == S_WAIT) || (state_q == S_CONV) ||
                 (state_q == S_EMIT);
      alu_a    = alu_a_q;
      alu_b    = alu_b_q;
      alu_cs   = alu_cs_q;
      dig_vld  = vld_q;
      dig_data = data_q;
      dig_idx  = idx_q;
      dig_clr  = clr_q;
      err      = err_q;
   end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: scoreboard bench for calc_seq_ctrl with a pipelined
// ALU model (latency 3) and a display-side digit/clear monitor.
module tb_calc_seq_ctrl;

   localparam int NDIG = 3;
   localparam int W    = 11;
   localparam int LAT  = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         key_vld = 1'b0;
   logic [3:0]   key_code = '0;
   logic [W-1:0] alu_a, alu_b, alu_s;
   logic [2:0]   alu_cs;
   logic         dig_vld;
   logic [3:0]   dig_data;
   logic [2:0]   dig_idx;
   logic         dig_rdy = 1'b1;
   logic         dig_clr, busy, err;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb [$];

   always #5 clk = ~clk;

   calc_seq_ctrl #(.NDIG(NDIG), .W(W), .ALU_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .key_vld(key_vld), .key_code(key_code),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cs(alu_cs), .alu_s(alu_s),
      .dig_vld(dig_vld), .dig_data(dig_data), .dig_idx(dig_idx),
      .dig_rdy(dig_rdy), .dig_clr(dig_clr),
      .busy(busy), .err(err)
   );

   // ALU model: result appears LAT-1 edges after operands change
   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [2:0] cs);
      case (cs)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b011:  return a - b;
         3'b100:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         default: return '0;
      endcase
   endfunction

   logic [W-1:0] p0 = '0, p1 = '0;
   always @(posedge clk) begin
      p0 <= alu_f(alu_a, alu_b, alu_cs);
      p1 <= p0;
   end
   assign alu_s = p1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] got);
      logic [7:0] e;
      if (sb.size() == 0) begin
         chk({tag, "_unexpected"}, 64'(got), 64'hEE);
      end else begin
         e = sb.pop_front();
         chk(tag, 64'(got), 64'(e));
      end
   endtask

   // display monitor: clear first, then any digit transfer of that cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (dig_clr) pop_chk("clr", 8'hFF);
         if (dig_vld && dig_rdy) pop_chk("dig", {1'b0, dig_idx, dig_data});
      end
   end

   task automatic exp_d(input logic [3:0] d, input logic [2:0] i);
      sb.push_back({1'b0, i, d});
   endtask

   task automatic exp_c();
      sb.push_back(8'hFF);
   endtask

   task automatic press(input logic [3:0] k);
      @(posedge clk);
      #1 key_vld = 1'b1;
      key_code = k;
      @(posedge clk);
      #1 key_vld = 1'b0;
   endtask

   task automatic key(input logic [3:0] k);
      press(k);
      repeat (3) @(posedge clk);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 300) begin
         @(posedge clk);
         #1 n++;
      end
      chk({tag, "_drain"}, 64'(sb.size()), 0);
      chk({tag, "_idle"}, 64'(busy), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   int n;
   logic [3:0] d0;
   logic [2:0] i0;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ops", {alu_a, alu_b, alu_cs}, 0);
      chk("rst_dig", {dig_vld, dig_data, dig_idx, dig_clr}, 0);
      chk("rst_st", {busy, err}, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // 12 + 7
      exp_c(); exp_d(1, 1); key(4'd1);
      exp_d(2, 2); key(4'd2);
      exp_c(); key(4'hE);
      exp_d(7, 1); key(4'd7);
      exp_c(); exp_d(1, 1); exp_d(9, 2);
      press(4'hF);
      n = 0;
      while (!dig_vld && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      chk("add_lat", 64'(n), 64'(LAT + 2));
      chk("add_a", 64'(alu_a), 12);
      chk("add_b", 64'(alu_b), 7);
      chk("add_cs", 64'(alu_cs), 3'b010);
      drain("add");
      chk("add_err", 64'(err), 0);

      // 5 - 8
      exp_c(); exp_d(5, 1); key(4'd5);
      exp_c(); key(4'hD);
      exp_d(8, 1); key(4'd8);
      exp_c();
`ifdef CALC_NEG_EN
      exp_d(4'hA, 1); exp_d(3, 2);
`else
      exp_d(0, 1);
`endif
      key(4'hF);
      drain("sub");
`ifdef CALC_NEG_EN
      chk("sub_err", 64'(err), 0);
`else
      chk("sub_err", 64'(err), 1);
`endif

      // 999 + 1 overflows
      exp_c(); exp_d(9, 1); key(4'd9);
      exp_d(9, 2); key(4'd9);
      exp_d(9, 3); key(4'd9);
      exp_c(); key(4'hE);
      exp_d(1, 1); key(4'd1);
      exp_c(); exp_d(0, 1); key(4'hF);
      drain("ovf");
      chk("ovf_err", 64'(err), 1);

      // fourth digit dropped: 123 + 1
      exp_c(); exp_d(1, 1); key(4'd1);
      exp_d(2, 2); key(4'd2);
      exp_d(3, 3); key(4'd3);
      key(4'd4);
      exp_c(); key(4'hE);
      exp_d(1, 1); key(4'd1);
      exp_c(); exp_d(1, 1); exp_d(2, 2); exp_d(4, 3);
      key(4'hF);
      drain("ndig");
      chk("ndig_a", 64'(alu_a), 123);
      chk("ndig_err", 64'(err), 0);

      // chain: 12 + 3 = 15, then - 5
      exp_c(); exp_d(1, 1); key(4'd1);
      exp_d(2, 2); key(4'd2);
      exp_c(); key(4'hE);
      exp_d(3, 1); key(4'd3);
      exp_c(); exp_d(1, 1); exp_d(5, 2); key(4'hF);
      drain("ch1");
      exp_c(); key(4'hD);
      exp_d(5, 1); key(4'd5);
      exp_c(); exp_d(1, 1); exp_d(0, 2); key(4'hF);
      drain("ch2");
      chk("ch_a", 64'(alu_a), 15);
      chk("ch_b", 64'(alu_b), 5);
      chk("ch_cs", 64'(alu_cs), 3'b011);

      // SLT 3 < 5
      exp_c(); exp_d(3, 1); key(4'd3);
      exp_c(); key(4'hC);
      exp_d(5, 1); key(4'd5);
      exp_c(); exp_d(1, 1); key(4'hF);
      drain("slt");
      chk("slt_cs", 64'(alu_cs), 3'b100);

      // backpressure during EMIT, keys ignored while busy
      exp_c(); exp_d(1, 1); key(4'd1);
      exp_d(2, 2); key(4'd2);
      exp_c(); key(4'hE);
      exp_d(7, 1); key(4'd7);
      dig_rdy = 1'b0;
      exp_c(); exp_d(1, 1); exp_d(9, 2);
      press(4'hF);
      n = 0;
      while (!dig_vld && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      chk("bp_vld", 64'(dig_vld), 1);
      d0 = dig_data;
      i0 = dig_idx;
      chk("bp_first", {i0, d0}, {3'd1, 4'd1});
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         key_vld = (i == 2) || (i == 5);
         key_code = (i == 2) ? 4'd5 : 4'hF;
         chk("bp_hold", {dig_vld, dig_idx, dig_data}, {1'b1, i0, d0});
      end
      key_vld = 1'b0;
      chk("bp_busy", 64'(busy), 1);
      dig_rdy = 1'b1;
      drain("bp");
      chk("bp_a", 64'(alu_a), 12);

      // reset in the middle of WAIT
      exp_c(); exp_d(1, 1); key(4'd1);
      exp_c(); key(4'hE);
      exp_d(2, 1); key(4'd2);
      exp_c();
      press(4'hF);
      @(negedge clk);
      chk("mid_busy", 64'(busy), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mr_ops", {alu_a, alu_b, alu_cs}, 0);
      chk("mr_dig", {dig_vld, dig_data, dig_idx, dig_clr}, 0);
      chk("mr_st", {busy, err}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      key(4'hD);
      exp_c(); exp_d(3, 1); key(4'd3);
      exp_c(); key(4'hE);
      exp_d(4, 1); key(4'd4);
      exp_c(); exp_d(7, 1); key(4'hF);
      drain("rst");
      chk("rst_add_a", 64'(alu_a), 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got 0 exp 1");
      $fatal(1);
   end

endmodule
